// File: rtl/nested_loop_counter.sv
// Nested loop counter: LEVELS cascaded mod-N counters (level 0 innermost) with a
// combinational carry chain, full-nest wrap pulse and optional one-shot completion.
module nested_loop_counter #(
    parameter int LEVELS        = 3,
    parameter int W             = 4,
    parameter int DEFAULT_BOUND = 10,
    parameter int ONESHOT       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                load,
    input  logic [LEVELS*W-1:0] bound,
    output logic [LEVELS*W-1:0] cnt,
    output logic [LEVELS-1:0]   co,
    output logic                wrap,
    output logic                done
);

    localparam logic [W-1:0] RST_BOUND = W'(DEFAULT_BOUND);
    localparam bit           ONE_PASS  = (ONESHOT != 0);

    // carry[i] is the carry into level i; carry[0] is the constant co[-1] = 1
    logic [LEVELS:0] carry;
    logic            step_en;
    logic            wrap_q, wrap_d;
    logic            done_q, done_d;

    assign carry[0] = 1'b1;
    assign co       = carry[LEVELS:1];
    assign step_en  = en && !(ONE_PASS && done_q);

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : gen_level
            logic [W-1:0] cnt_q, cnt_d;
            logic [W-1:0] bnd_q, bnd_d;
            logic [W-1:0] last_val;

            // A zero bound behaves as N=1, so the terminal count is 0 either way
            assign last_val          = (bnd_q == '0) ? '0 : bnd_q - W'(1);
            assign carry[gi+1]       = (cnt_q == last_val) && carry[gi];
            assign cnt[gi*W +: W]    = cnt_q;

            always_comb begin
                cnt_d = cnt_q;
                bnd_d = bnd_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (load) begin
                    cnt_d = '0;
                    bnd_d = bound[gi*W +: W];
                end else if (step_en && carry[gi]) begin
                    cnt_d = carry[gi+1] ? '0 : cnt_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    bnd_q <= RST_BOUND;
                end else begin
                    cnt_q <= cnt_d;
                    bnd_q <= bnd_d;
                end
            end
        end
    endgenerate

    always_comb begin
        wrap_d = 1'b0;
        done_d = done_q;
        if (clr || load) begin
            done_d = 1'b0;
        end else if (step_en && carry[LEVELS]) begin
            wrap_d = 1'b1;
            if (ONE_PASS) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: doc/nested_loop_counter.md
NESTED_LOOP_COUNTER -- requirements
Module: nested_loop_counter

Interface
REQ-001 SHALL have parameter LEVELS, default 3, giving the number of nested loop levels (1..4); level 0 is the innermost.
REQ-002 SHALL have parameter W, default 4, giving the per-level count width.
REQ-003 SHALL have parameter DEFAULT_BOUND, default 10, giving the per-level loop count loaded at reset.
REQ-004 SHALL have parameter ONESHOT, default 0: 0 = free-running wrap, 1 = stop after one full pass.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: advance the nest by one step.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of counts and done.
REQ-009 SHALL have port load, input, 1 bit: synchronous latch of bound and clear of counts.
REQ-010 SHALL have port bound, input, LEVELS*W bits: per-level loop count N, level i in bits [i*W +: W].
REQ-011 SHALL have port cnt, output, LEVELS*W bits: per-level count, same packing as bound.
REQ-012 SHALL have port co, output, LEVELS bits: per-level carry-out.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse after a full-nest rollover.
REQ-014 SHALL have port done, output, 1 bit: sticky completion flag, meaningful only when ONESHOT=1.

Function
REQ-015 SHALL hold an internal bound register bnd[i] per level; effective N[i] = bnd[i], except bnd[i]=0 SHALL be treated as N=1.
REQ-016 SHALL count each level 0..N[i]-1.
REQ-017 SHALL drive co[i] combinationally: co[i] = (cnt[i]==N[i]-1) AND co[i-1], with co[-1] = 1; co SHALL be independent of en.
REQ-018 On en=1, level 0 SHALL step every cycle; level i>0 SHALL step only when co[i-1]=1.
REQ-019 A stepping level with co[i]=1 SHALL go to 0; otherwise it SHALL increment by 1.
REQ-020 When en=1 and co[LEVELS-1]=1, all levels SHALL return to 0 and wrap SHALL pulse high for exactly the next cycle.
REQ-021 With ONESHOT=1, the rollover in REQ-020 SHALL also set done; while done=1, en SHALL be ignored and cnt SHALL hold at all-zero.
REQ-022 With ONESHOT=0, done SHALL stay 0.
REQ-023 Priority SHALL be clr > load > en, resolved in the same cycle.
REQ-024 clr=1 SHALL zero cnt, done and wrap on the next edge; bnd SHALL be unchanged.
REQ-025 load=1 SHALL latch bound into bnd, zero cnt, done and wrap, and suppress en that cycle; the new bounds SHALL drive co from the next cycle.
REQ-026 Latency: cnt and wrap SHALL reflect an en, clr or load one clock after the sampling edge.
REQ-027 Arithmetic SHALL stay W bits per level with no overflow into the neighbouring level field.

Reset
REQ-028 rst=0 SHALL immediately and asynchronously set cnt=0, wrap=0, done=0, and every bnd[i]=DEFAULT_BOUND truncated to W bits.
REQ-029 Release of rst SHALL be sampled synchronously; the first step SHALL occur on the first rising edge with rst=1 and en=1.
REQ-030 Assertion of rst mid-count SHALL abandon the pass with no wrap pulse.

Verification (LEVELS=3, W=4, DEFAULT_BOUND=10 unless stated)
REQ-031 Reset pulse, then en=1 held for 1000 cycles -> co[0] high whenever cnt[0]=9; co[1] high at cnt={x,9,9}; co[2] high at {9,9,9}; single wrap pulse the cycle after the 1000th step; cnt={0,0,0}.
REQ-032 load with bound={2,3,4} (level2..level0), then 24 en cycles -> wrap pulses after step 24; co[2] high only at cnt={1,2,3}.
REQ-033 ONESHOT=1, bound={2,3,4}, 30 en cycles -> done=1 after step 24, cnt={0,0,0} held through steps 25-30; clr -> done=0 and counting resumes.
REQ-034 At cnt={0,3,7}, clr=1 with en=1 and load=1 in the same cycle -> next cycle cnt={0,0,0} and bnd unchanged.
REQ-035 bound={0,2,0} -> levels 0 and 2 stay at 0 with co[0]=1; wrap pulses every 2 en steps.
REQ-036 rst=0 asserted between clock edges at cnt={4,5,6} -> cnt={0,0,0} before the next edge; bnd returns to 10 for every level; no wrap pulse.
